// File: rtl/countdown_timer_if.sv
// Control and display bundle of the countdown timer.
// master: the controlling side (buttons in, display out).
// slave : the timer itself.
interface countdown_timer_if;
    logic       start;
    logic       pause;
    logic       clear;
    logic       set_sec;
    logic       set_min;
    logic       set_hr;
    logic [5:0] sec;
    logic [5:0] min;
    logic [4:0] hr;
    logic       running;
    logic       expired;
    logic       buzzer;

    modport master (
        output start, pause, clear, set_sec, set_min, set_hr,
        input  sec, min, hr, running, expired, buzzer
    );

    modport slave (
        input  start, pause, clear, set_sec, set_min, set_hr,
        output sec, min, hr, running, expired, buzzer
    );
endinterface

// File: rtl/countdown_timer.sv
// Countdown timer: hh:mm:ss loaded with increment buttons, counted down
// once per 1 Hz tick, with pause/resume, latched expiry and a buzzer pulse
// lasting ALARM_SECS periods.
//
// state    | meaning
// ---------+---------------------------------------------------------
// S_IDLE   | time editable with set_*, start launches if time nonzero
// S_RUN    | decrementing once per edge, pause freezes
// S_PAUSED | time held, start resumes
// S_DONE   | reached 0:00:00, expired high, buzzer timed, start acks
module countdown_timer #(
    parameter int ALARM_SECS = 10
) (
    input  logic               clk_1Hz,
    input  logic               rst,
    countdown_timer_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_PAUSED = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam logic [7:0] ALARM_LEN = 8'(ALARM_SECS);

    state_t     state_q,   state_d;
    logic [5:0] sec_q,     sec_d;
    logic [5:0] min_q,     min_d;
    logic [4:0] hr_q,      hr_d;
    logic       running_q, running_d;
    logic       expired_q, expired_d;
    logic       buzzer_q,  buzzer_d;
    // Periods the buzzer has been high so far, saturating at ALARM_LEN.
    logic [7:0] bz_cnt_q,  bz_cnt_d;

    logic time_zero;
    assign time_zero = (sec_q == 6'd0) && (min_q == 6'd0) && (hr_q == 5'd0);

    // State and datapath registers, cleared asynchronously by rst.
    always_ff @(posedge clk_1Hz or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            sec_q     <= 6'd0;
            min_q     <= 6'd0;
            hr_q      <= 5'd0;
            running_q <= 1'b0;
            expired_q <= 1'b0;
            buzzer_q  <= 1'b0;
            bz_cnt_q  <= 8'd0;
        end else begin
            state_q   <= state_d;
            sec_q     <= sec_d;
            min_q     <= min_d;
            hr_q      <= hr_d;
            running_q <= running_d;
            expired_q <= expired_d;
            buzzer_q  <= buzzer_d;
            bz_cnt_q  <= bz_cnt_d;
        end
    end

    // Next state, time update and buzzer timing; clear overrides everything.
    always_comb begin
        state_d  = state_q;
        sec_d    = sec_q;
        min_d    = min_q;
        hr_d     = hr_q;
        buzzer_d = buzzer_q;
        bz_cnt_d = bz_cnt_q;

        if (bus.clear) begin
            state_d  = S_IDLE;
            sec_d    = 6'd0;
            min_d    = 6'd0;
            hr_d     = 5'd0;
            buzzer_d = 1'b0;
            bz_cnt_d = 8'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start && !time_zero) begin
                        state_d = S_RUN;
                    end else begin
                        // A start at 0:00:00 is ignored, so edits still apply.
                        if (bus.set_sec) sec_d = (sec_q == 6'd59) ? 6'd0 : sec_q + 6'd1;
                        if (bus.set_min) min_d = (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
                        if (bus.set_hr)  hr_d  = (hr_q  == 5'd23) ? 5'd0 : hr_q  + 5'd1;
                    end
                end
                S_RUN: begin
                    if (bus.pause) begin
                        state_d = S_PAUSED;
                    end else begin
                        if (sec_q != 6'd0) begin
                            sec_d = sec_q - 6'd1;
                        end else if (min_q != 6'd0) begin
                            min_d = min_q - 6'd1;
                            sec_d = 6'd59;
                        end else if (hr_q != 5'd0) begin
                            hr_d  = hr_q - 5'd1;
                            min_d = 6'd59;
                            sec_d = 6'd59;
                        end
                        if ((sec_d == 6'd0) && (min_d == 6'd0) && (hr_d == 5'd0)) begin
                            state_d  = S_DONE;
                            buzzer_d = 1'b1;
                            bz_cnt_d = 8'd1;
                        end
                    end
                end
                S_PAUSED: begin
                    if (bus.start) state_d = S_RUN;
                end
                S_DONE: begin
                    if (bus.start) begin
                        state_d  = S_IDLE;
                        buzzer_d = 1'b0;
                        bz_cnt_d = 8'd0;
                    end else if (bz_cnt_q < ALARM_LEN) begin
                        bz_cnt_d = bz_cnt_q + 8'd1;
                        buzzer_d = 1'b1;
                    end else begin
                        buzzer_d = 1'b0;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        running_d = (state_d == S_RUN);
        expired_d = (state_d == S_DONE);
    end

    assign bus.sec     = sec_q;
    assign bus.min     = min_q;
    assign bus.hr      = hr_q;
    assign bus.running = running_q;
    assign bus.expired = expired_q;
    assign bus.buzzer  = buzzer_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer: directed scenarios followed by random button
// traffic, all compared against a total-seconds reference model.
module tb_countdown_timer;

    localparam int ALARM = 3;
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2, M_DONE = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    countdown_timer_if bus ();

    countdown_timer #(.ALARM_SECS(ALARM)) dut (
        .clk_1Hz (clk),
        .rst     (rst),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: mode, h/m/s fields, edges spent in DONE.
    int m_mode, m_h, m_m, m_s, m_age;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = M_IDLE; m_h = 0; m_m = 0; m_s = 0; m_age = 0;
    endtask

    task automatic model_edge();
        int t;
        t = m_h * 3600 + m_m * 60 + m_s;
        if (bus.clear) begin
            m_mode = M_IDLE; m_h = 0; m_m = 0; m_s = 0; m_age = 0;
        end else begin
            case (m_mode)
                M_IDLE: begin
                    if (bus.start && t != 0) m_mode = M_RUN;
                    else begin
                        if (bus.set_sec) m_s = (m_s + 1) % 60;
                        if (bus.set_min) m_m = (m_m + 1) % 60;
                        if (bus.set_hr)  m_h = (m_h + 1) % 24;
                    end
                end
                M_RUN: begin
                    if (bus.pause) m_mode = M_PAUSED;
                    else begin
                        t = t - 1;
                        m_h = t / 3600; m_m = (t / 60) % 60; m_s = t % 60;
                        if (t == 0) begin m_mode = M_DONE; m_age = 0; end
                    end
                end
                M_PAUSED: if (bus.start) m_mode = M_RUN;
                default: begin
                    if (bus.start) m_mode = M_IDLE;
                    else if (m_age < 1000) m_age++;
                end
            endcase
        end
    endtask

    task automatic compare_all(input string tag);
        chk({tag, ".sec"},     int'(bus.sec),     m_s);
        chk({tag, ".min"},     int'(bus.min),     m_m);
        chk({tag, ".hr"},      int'(bus.hr),      m_h);
        chk({tag, ".running"}, int'(bus.running), int'(m_mode == M_RUN));
        chk({tag, ".expired"}, int'(bus.expired), int'(m_mode == M_DONE));
        chk({tag, ".buzzer"},  int'(bus.buzzer),  int'(m_mode == M_DONE && m_age < ALARM));
    endtask

    task automatic drive(input bit st, input bit pa, input bit cl,
                         input bit ss, input bit sm, input bit sh);
        bus.start = st; bus.pause = pa; bus.clear = cl;
        bus.set_sec = ss; bus.set_min = sm; bus.set_hr = sh;
    endtask

    // One clock edge: update the model from the sampled inputs, check 1 ns later.
    task automatic tick(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        compare_all(tag);
    endtask

    task automatic press(input bit ss, input bit sm, input bit sh, input int n);
        drive(0, 0, 0, ss, sm, sh);
        for (int i = 0; i < n; i++) tick("press");
        drive(0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_clear();
        drive(0, 0, 1, 0, 0, 0);
        tick("clear");
        drive(0, 0, 0, 0, 0, 0);
    endtask

    task automatic async_reset_pulse(input string tag);
        #2 rst = 1'b1;
        #1;
        model_reset();
        compare_all(tag);
        rst = 1'b0;
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0);
        model_reset();
        #2;
        compare_all("reset");
        #10 rst = 1'b0;

        // 1: three seconds, countdown and expiry, buzzer length, acknowledge
        press(1, 0, 0, 3);
        chk("t1.loaded", int'(bus.sec), 3);
        drive(1, 0, 0, 0, 0, 0); tick("t1.start");
        chk("t1.nodec", int'(bus.sec), 3);
        drive(0, 0, 0, 0, 0, 0);
        tick("t1.e1"); chk("t1.sec2", int'(bus.sec), 2);
        tick("t1.e2"); chk("t1.sec1", int'(bus.sec), 1);
        tick("t1.e3"); chk("t1.sec0", int'(bus.sec), 0);
        chk("t1.expired", int'(bus.expired), 1);
        chk("t1.buzzer", int'(bus.buzzer), 1);
        chk("t1.running", int'(bus.running), 0);
        tick("t1.b2"); chk("t1.buz2", int'(bus.buzzer), 1);
        tick("t1.b3"); chk("t1.buz3", int'(bus.buzzer), 1);
        tick("t1.b4"); chk("t1.buzoff", int'(bus.buzzer), 0);
        chk("t1.exp_hold", int'(bus.expired), 1);
        tick("t1.b5"); chk("t1.buzsat", int'(bus.buzzer), 0);
        drive(1, 0, 0, 0, 0, 0); tick("t1.ack");
        chk("t1.ack_exp", int'(bus.expired), 0);
        drive(0, 0, 0, 0, 0, 0);

        // 2: borrow chain
        do_clear();
        press(0, 0, 1, 1);
        drive(1, 0, 0, 0, 0, 0); tick("t2.start");
        drive(0, 0, 0, 0, 0, 0); tick("t2.dec");
        chk("t2.hr", int'(bus.hr), 0);
        chk("t2.min", int'(bus.min), 59);
        chk("t2.sec", int'(bus.sec), 59);
        do_clear();
        press(0, 1, 0, 1);
        drive(1, 0, 0, 0, 0, 0); tick("t2b.start");
        drive(0, 0, 0, 0, 0, 0); tick("t2b.dec");
        chk("t2b.min", int'(bus.min), 0);
        chk("t2b.sec", int'(bus.sec), 59);

        // 3: field wraps without carry, start at zero ignored
        do_clear();
        press(0, 0, 1, 24); chk("t3.hr_wrap", int'(bus.hr), 0);
        press(0, 0, 1, 5);
        press(0, 1, 0, 60); chk("t3.min_wrap", int'(bus.min), 0);
        chk("t3.hr_keep", int'(bus.hr), 5);
        press(0, 1, 0, 3);
        press(1, 0, 0, 60); chk("t3.sec_wrap", int'(bus.sec), 0);
        chk("t3.min_keep", int'(bus.min), 3);
        do_clear();
        drive(1, 0, 0, 0, 0, 0); tick("t3.zstart");
        chk("t3.zidle", int'(bus.running), 0);
        drive(0, 0, 0, 0, 0, 0);

        // 4: pause, resume, start+pause while paused
        press(1, 0, 0, 5);
        drive(1, 0, 0, 0, 0, 0); tick("t4.start");
        drive(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            tick("t4.pause");
            chk("t4.hold", int'(bus.sec), 5);
        end
        drive(1, 0, 0, 0, 0, 0); tick("t4.resume");
        chk("t4.res_hold", int'(bus.sec), 5);
        drive(0, 0, 0, 0, 0, 0); tick("t4.dec");
        chk("t4.sec4", int'(bus.sec), 4);
        drive(0, 1, 0, 0, 0, 0); tick("t4.pause2");
        drive(1, 1, 0, 0, 0, 0); tick("t4.both");
        chk("t4.both_run", int'(bus.running), 1);
        drive(0, 0, 0, 0, 0, 0); tick("t4.dec2");
        chk("t4.sec3", int'(bus.sec), 3);

        // 6: clear beats start during RUN, async reset mid-RUN
        drive(1, 0, 1, 0, 0, 0); tick("t6.clear");
        chk("t6.idle", int'(bus.running), 0);
        chk("t6.sec0", int'(bus.sec), 0);
        press(1, 0, 0, 5);
        drive(1, 0, 0, 0, 0, 0); tick("t6.start");
        drive(0, 0, 0, 0, 0, 0); tick("t6.dec");
        async_reset_pulse("t6.rst");
        chk("t6.rst_run", int'(bus.running), 0);

        // Random traffic
        for (int c = 0; c < 4000; c++) begin
            drive($urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0,
                  $urandom_range(0, 59) == 0, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 5) == 0, $urandom_range(0, 40) == 0);
            if ($urandom_range(0, 499) == 0) async_reset_pulse("rnd.rst");
            else tick("rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
Countdown timer for the digital clock design, the down-counting counterpart of the time-of-day counter. The user loads hours, minutes and seconds with increment buttons, then starts a countdown. The countdown decrements once per 1 Hz tick, can be paused and resumed, and flags expiry with a latched expired flag and a timed buzzer pulse. Outputs use the same sec/min/hr encoding as the time-of-day counter, so they feed the existing BCD/7-segment display path unchanged.

Parameters:
ALARM_SECS, 10, number of clk_1Hz periods the buzzer stays asserted after expiry; legal range 1..255.

Ports:
clk_1Hz   input   1  1 Hz clock; every register updates on its rising edge.
rst       input   1  reset, asynchronous, active-high.
start     input   1  start/resume/acknowledge; level sampled on each clock edge.
pause     input   1  pause request while running; level sampled.
clear     input   1  abort and zero the timer; level sampled; highest priority.
set_sec   input   1  increment seconds while IDLE.
set_min   input   1  increment minutes while IDLE.
set_hr    input   1  increment hours while IDLE.
sec       output  6  remaining seconds, 0-59.
min       output  6  remaining minutes, 0-59.
hr        output  5  remaining hours, 0-23.
running   output  1  high when state is RUN.
expired   output  1  high when state is DONE.
buzzer    output  1  alarm drive.

Behaviour:
- Reset (async): state=IDLE; sec=min=hr=0; running=expired=buzzer=0; buzzer counter=0.
- All outputs are registered. There is no combinational path from any input to any output.
- Input priority on each edge: clear > start/pause > set_*.
- clear in any state: go to IDLE; sec=min=hr=0; buzzer=0.
- IDLE:
  - set_sec: sec increments, 59 wraps to 0, no carry.
  - set_min: min increments, 59 wraps to 0, no carry.
  - set_hr: hr increments, 23 wraps to 0.
  - Multiple set_* inputs high together: all of them apply in the same edge.
  - start with time != 0:00:00: go to RUN. No decrement on this edge. set_* inputs are ignored on this edge.
  - start with time == 0:00:00: ignored, stay in IDLE.
- RUN:
  - pause high: go to PAUSED. No decrement on this edge.
  - Otherwise decrement once per edge using a borrow chain:
    - sec>0: sec-1.
    - sec=0, min>0: min-1, sec=59.
    - sec=min=0, hr>0: hr-1, min=59, sec=59.
  - If the decremented value is 0:00:00, go to DONE on the same edge. expired=1 and buzzer=1 are registered on that edge.
  - start and set_* are ignored.
- PAUSED:
  - Time holds.
  - start: go to RUN, no decrement on this edge. If start and pause are both high, start wins.
  - set_* inputs are ignored.
- DONE:
  - Time holds at 0:00:00. expired=1.
  - buzzer stays high for exactly ALARM_SECS clock periods from DONE entry, then drops to 0 and remains 0.
  - The buzzer counter saturates; it does not wrap.
  - start: acknowledge. Go to IDLE, expired=0, buzzer=0.
  - set_* inputs are ignored.
- Latency: a count loaded as N seconds of total time expires on the N-th edge after the start edge.
- Reset asserted mid-operation: immediate return to reset values, regardless of state.

Test Plan:
1. Reset, then set_sec x3, then start -> edges after start show sec 2,1,0; expired=1 and buzzer=1 on the 3rd edge; running=0 from that edge.
2. Load 1:00:00, start -> first decrement gives 0:59:59; the borrow chain is correct at each boundary. Load 0:01:00 -> 0:00:59.
3. In IDLE, set_hr at 23 -> 0. set_min at 59 -> 0, with hr unchanged. set_sec at 59 -> 0, with min unchanged. start at 0:00:00 -> stays IDLE.
4. RUN at 0:00:05, pause for 4 edges -> holds 0:00:05. Then start -> next edge holds, the following edge shows 0:00:04. start+pause together while PAUSED -> resumes.
5. With ALARM_SECS=3 -> buzzer high for exactly 3 periods, expired stays 1. start -> IDLE, expired=0.
6. clear during RUN together with start -> IDLE, time 0. Async rst pulse between edges mid-RUN -> outputs zero immediately, with no clock edge required.
